timer_device: RTL and testbench

Memory-mapped timer peripheral that sits directly downstream of the bus interconnect as one of its device (slave) ports. It accepts single-cycle bus requests on the device-side signals (req/addr/we/wdata) and returns read data on the following cycle. Internally it runs a prescaled 32-bit up-counter with a compare match, one-shot or periodic mode, and a level interrupt output for a host.

---
 rtl/timer_device_if.sv | 28 ++
 rtl/timer_device.sv | 143 ++++++++++++++
 tb/tb_timer_device.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_device_if.sv
// Device-side bus bundle between the interconnect and the timer peripheral.
// The interconnect drives the request; the timer returns registered read data.
interface timer_device_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) ();
    logic                    device_req_i;
    logic [AddressWidth-1:0] device_addr_i;
    logic                    device_we_i;
    logic [DataWidth-1:0]    device_wdata_i;
    logic [DataWidth-1:0]    device_rdata_o;

    modport master (
        output device_req_i,
        output device_addr_i,
        output device_we_i,
        output device_wdata_i,
        input  device_rdata_o
    );

    modport slave (
        input  device_req_i,
        input  device_addr_i,
        input  device_we_i,
        input  device_wdata_i,
        output device_rdata_o
    );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare match,
// one-shot or periodic mode and a level interrupt.
module timer_device #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int PrescaleWidth = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    timer_device_if.slave  bus,
    output logic           irq_o
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    logic                     en;
    logic                     periodic;
    logic                     irq_en;
    logic [PrescaleWidth-1:0] prescale;
    logic [PrescaleWidth-1:0] pre_cnt;
    logic [31:0]              count;
    logic [31:0]              compare;
    logic                     pending;
    logic [DataWidth-1:0]     read_value;

    logic [2:0] sel;
    logic       wr;
    logic       rd;
    logic       wr_ctrl;
    logic       wr_prescale;
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       tick;
    logic       match;

    // Only addr[4:2] selects a register; the rest is already decoded upstream.
    logic unused_addr;
    assign unused_addr = ^{bus.device_addr_i[AddressWidth-1:5], bus.device_addr_i[1:0]};

    assign sel         = bus.device_addr_i[4:2];
    assign wr          = bus.device_req_i & bus.device_we_i;
    assign rd          = bus.device_req_i & ~bus.device_we_i;
    assign wr_ctrl     = wr && (sel == REG_CTRL);
    assign wr_prescale = wr && (sel == REG_PRESCALE);
    assign wr_count    = wr && (sel == REG_COUNT);
    assign wr_compare  = wr && (sel == REG_COMPARE);
    assign wr_status   = wr && (sel == REG_STATUS);

    // A tick is the last cycle of each prescale period; match is judged on the pre-update COUNT.
    assign tick  = en && (pre_cnt == prescale);
    assign match = tick && (count == compare);

    assign irq_o = pending & irq_en;

    // Control bits; a bus write to CTRL overrides the one-shot self-disable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
        end else if (wr_ctrl) begin
            en       <= bus.device_wdata_i[0];
            periodic <= bus.device_wdata_i[1];
            irq_en   <= bus.device_wdata_i[2];
        end else if (match && !periodic) begin
            en <= 1'b0;
        end
    end

    // Prescale divider restarts whenever its period or the enable is rewritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_cnt <= '0;
        end else if (wr_ctrl || wr_prescale || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PrescaleWidth'(1);
        end
    end

    // PRESCALE and COMPARE are plain software-owned registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale <= '0;
            compare  <= 32'hFFFF_FFFF;
        end else begin
            if (wr_prescale) prescale <= bus.device_wdata_i[PrescaleWidth-1:0];
            if (wr_compare)  compare  <= bus.device_wdata_i[31:0];
        end
    end

    // Main counter; a software load beats the tick's increment or periodic restart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.device_wdata_i[31:0];
        end else if (match && periodic) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 32'd1;
        end
    end

    // Pending flag: a new match wins over a simultaneous write-one-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end else if (wr_status && bus.device_wdata_i[0]) begin
            pending <= 1'b0;
        end
    end

    // Read mux over the register values as they stand in the request cycle.
    always_comb begin
        read_value = '0;
        case (sel)
            REG_CTRL:     read_value = {{(DataWidth-3){1'b0}}, irq_en, periodic, en};
            REG_PRESCALE: read_value = {{(DataWidth-PrescaleWidth){1'b0}}, prescale};
            REG_COUNT:    read_value = count;
            REG_COMPARE:  read_value = compare;
            REG_STATUS:   read_value = {{(DataWidth-1){1'b0}}, pending};
            default:      read_value = '0;
        endcase
    end

    // Read data is captured only on read requests and held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.device_rdata_o <= '0;
        end else if (rd) begin
            bus.device_rdata_o <= read_value;
        end
    end

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios plus randomized
// bus traffic compared every cycle against a register-level reference model.
module tb_timer_device;

    logic clk_i;
    logic rst_ni;
    logic irq_o;

    timer_device_if bus ();

    timer_device dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .irq_o  (irq_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state: register contents plus position within the prescale period.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre;
    logic [15:0] m_phase;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_pend;
    logic [31:0] m_rdata;

    logic [31:0] rst_vals [8] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m_ctrl  = 3'b000;
        m_pre   = 16'h0;
        m_phase = 16'h0;
        m_count = 32'h0;
        m_cmp   = 32'hFFFF_FFFF;
        m_pend  = 1'b0;
        m_rdata = 32'h0;
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        case (idx)
            0:       return {29'h0, m_ctrl};
            1:       return {16'h0, m_pre};
            2:       return m_count;
            3:       return m_cmp;
            4:       return {31'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the timer's rules: timer behaviour first, bus write layered on top.
    task automatic modelStep(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        bit tick;
        bit hit;
        idx  = int'(addr[4:2]);
        tick = m_ctrl[0] && (m_phase == m_pre);
        hit  = tick && (m_count == m_cmp);
        if (req && !we) m_rdata = modelRead(idx);
        if (m_ctrl[0]) m_phase = tick ? 16'h0 : m_phase + 16'h1;
        else           m_phase = 16'h0;
        if (hit) begin
            m_pend = 1'b1;
            if (m_ctrl[1]) m_count = 32'h0;
            else begin
                m_count   = m_count + 32'h1;
                m_ctrl[0] = 1'b0;
            end
        end else if (tick) begin
            m_count = m_count + 32'h1;
        end
        if (req && we) begin
            case (idx)
                0: begin m_ctrl = wdata[2:0];  m_phase = 16'h0; end
                1: begin m_pre  = wdata[15:0]; m_phase = 16'h0; end
                2: m_count = wdata;
                3: m_cmp   = wdata;
                4: if (wdata[0] && !hit) m_pend = 1'b0;
                default: ;
            endcase
        end
    endtask

    // Drive one bus cycle, advance the model on the edge and compare both outputs.
    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.device_req_i   = req;
        bus.device_we_i    = we;
        bus.device_addr_i  = addr;
        bus.device_wdata_i = wdata;
        @(posedge clk_i);
        modelStep(req, we, addr, wdata);
        cyc++;
        #1;
        checkOutput("rdata", bus.device_rdata_o, m_rdata);
        checkOutput("irq", {31'h0, irq_o}, {31'h0, m_pend & m_ctrl[2]});
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, 32'h0);
        data = bus.device_rdata_o;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        bus.device_req_i   = 1'b0;
        bus.device_we_i    = 1'b0;
        bus.device_addr_i  = 32'h0;
        bus.device_wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        modelReset();
        rst_ni = 1'b1;
        checkOutput("rst_rdata", bus.device_rdata_o, 32'h0);
        checkOutput("rst_irq", {31'h0, irq_o}, 32'h0);
    endtask

    task automatic checkResetValues(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            readReg(32'(i * 4), d);
            checkOutput(tag, d, rst_vals[i]);
            checkOutput({tag, "_irq"}, {31'h0, irq_o}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] d;
        int start;
        int idx;
        logic [31:0] addr;
        logic [31:0] wdata;

        rst_ni = 1'b0;
        modelReset();

        // Reset values of every offset.
        doReset();
        checkResetValues("reset_rd");

        // Periodic mode with prescale 3: first match 24 cycles after enable, then every 24.
        writeReg(32'h04, 32'd3);
        writeReg(32'h0C, 32'd5);
        writeReg(32'h00, 32'b111);
        start = cyc;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (irq_o) break;
        end
        checkOutput("per_first", 32'(cyc - start), 32'd24);
        writeReg(32'h10, 32'h1);
        readReg(32'h08, d);
        checkOutput("per_wrap", d, 32'h0);
        for (int i = 0; i < 100; i++) begin
            idle();
            if (irq_o) break;
        end
        checkOutput("per_second", 32'(cyc - start), 32'd48);

        // One-shot: match on the third tick, then frozen with en cleared.
        doReset();
        writeReg(32'h0C, 32'd2);
        writeReg(32'h00, 32'b101);
        repeat (5) idle();
        readReg(32'h08, d);
        checkOutput("os_count", d, 32'd3);
        readReg(32'h00, d);
        checkOutput("os_ctrl", d, 32'b100);
        readReg(32'h10, d);
        checkOutput("os_pending", d, 32'd1);
        checkOutput("os_irq", {31'h0, irq_o}, 32'd1);
        repeat (3) idle();
        readReg(32'h08, d);
        checkOutput("os_frozen", d, 32'd3);

        // Asynchronous reset in the middle of a cycle with irq asserted.
        readReg(32'h0C, d);
        checkOutput("ar_pre_rdata", d, 32'd2);
        #3;
        rst_ni = 1'b0;
        #1;
        checkOutput("ar_irq", {31'h0, irq_o}, 32'h0);
        checkOutput("ar_rdata", bus.device_rdata_o, 32'h0);
        doReset();
        checkResetValues("ar_after");

        // W1C on the match cycle: set wins; later isolated writes behave as W1C.
        doReset();
        writeReg(32'h0C, 32'd3);
        writeReg(32'h00, 32'b111);
        repeat (3) idle();
        writeReg(32'h10, 32'h1);
        checkOutput("w1c_collide_irq", {31'h0, irq_o}, 32'd1);
        readReg(32'h10, d);
        checkOutput("w1c_collide_pend", d, 32'd1);
        writeReg(32'h00, 32'b100);
        writeReg(32'h10, 32'h0);
        readReg(32'h10, d);
        checkOutput("w1c_zero", d, 32'd1);
        writeReg(32'h10, 32'h1);
        checkOutput("w1c_irq_low", {31'h0, irq_o}, 32'd0);
        readReg(32'h10, d);
        checkOutput("w1c_clear", d, 32'd0);

        // Counter wrap and a COUNT load on a tick cycle.
        doReset();
        writeReg(32'h08, 32'hFFFF_FFFE);
        writeReg(32'h0C, 32'h10);
        writeReg(32'h00, 32'b001);
        idle();
        readReg(32'h08, d);
        checkOutput("wrap_ff", d, 32'hFFFF_FFFF);
        readReg(32'h08, d);
        checkOutput("wrap_0", d, 32'h0);
        readReg(32'h08, d);
        checkOutput("wrap_1", d, 32'h1);
        readReg(32'h10, d);
        checkOutput("wrap_nopend", d, 32'h0);
        writeReg(32'h08, 32'h100);
        readReg(32'h08, d);
        checkOutput("load_tick", d, 32'h100);

        // Randomized traffic with small values so matches happen often.
        doReset();
        writeReg(32'h00, 32'b111);
        for (int i = 0; i < 600; i++) begin
            idx  = int'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_FFE0) | 32'(idx * 4) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: idle();
                4, 5, 6:    applyStimulus(1'b1, 1'b0, addr, $urandom);
                default: begin
                    case (idx)
                        0:       wdata = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
                        1:       wdata = 32'($urandom_range(0, 3));
                        2:       wdata = 32'($urandom_range(0, 12));
                        3:       wdata = 32'($urandom_range(0, 12));
                        default: wdata = $urandom;
                    endcase
                    applyStimulus(1'b1, 1'b1, addr, wdata);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
